// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/execute/writeback controller for the 8-bit RISC core
module instr_sequencer #(
  parameter int              PC_W   = 8,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Cen,
  input  logic [15:0]     InstrIn,
  input  logic            ZeroIn,
  output logic [PC_W-1:0] PC,
  output logic [2:0]      SelA,
  output logic [2:0]      SelB,
  output logic [2:0]      SelWR,
  output logic            WE,
  output logic [2:0]      AluOp,
  output logic            ImmSel,
  output logic [7:0]      Imm,
  output logic            Halted
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    WRITEBACK = 3'd3,
    HALT      = 3'd4
  } state_t;

  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BRZ  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t          state, stateNext;
  logic [PC_W-1:0] pcReg, pcNext;
  logic [15:0]     ir;
  logic            zFlag;
  logic [3:0]      opcode;
  logic            isAlu, doesWrite;

  assign opcode    = ir[15:12];
  assign isAlu     = (opcode >= 4'h1) && (opcode <= 4'h6);
  assign doesWrite = (opcode >= 4'h1) && (opcode <= OP_LDI);

  always_comb begin
    stateNext = state;
    case (state)
      FETCH:     stateNext = DECODE;
      DECODE:    stateNext = (opcode == OP_HALT) ? HALT : EXECUTE;
      EXECUTE:   stateNext = WRITEBACK;
      WRITEBACK: stateNext = FETCH;
      HALT:      stateNext = HALT;
      default:   stateNext = FETCH;
    endcase
  end

  always_comb begin
    pcNext = pcReg + PC_W'(1);
    case (opcode)
      OP_JMP:  pcNext = PC_W'(ir[7:0]);
      OP_BRZ:  if (zFlag) pcNext = PC_W'(ir[7:0]);
      OP_HALT: pcNext = pcReg;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= FETCH;
      pcReg <= RST_PC;
      ir    <= 16'h0000;
      zFlag <= 1'b0;
    end else if (Cen) begin
      state <= stateNext;
      if (state == FETCH) ir <= InstrIn;
      if (state == EXECUTE && isAlu) zFlag <= ZeroIn;
      if (state == WRITEBACK) pcReg <= pcNext;
    end
  end

  always_comb begin
    AluOp = 3'd0;
    case (opcode)
      4'h1: AluOp = 3'd0;
      4'h2: AluOp = 3'd1;
      4'h3: AluOp = 3'd2;
      4'h4: AluOp = 3'd3;
      4'h5: AluOp = 3'd4;
      4'h6: AluOp = 3'd5;
      default: AluOp = 3'd0;
    endcase
  end

  // Register-file controls come straight from IR so they stay stable across all post-fetch cycles.
  assign PC     = pcReg;
  assign SelA   = ir[8:6];
  assign SelB   = ir[5:3];
  assign SelWR  = ir[11:9];
  assign Imm    = ir[7:0];
  assign ImmSel = (opcode == OP_LDI);
  assign Halted = (state == HALT);
  // Gating with Cen and Rst keeps a stalled or interrupted writeback from reaching the register file.
  assign WE     = (state == WRITEBACK) && Cen && !Rst && doesWrite;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed scoreboard bench for instr_sequencer
module tb_instr_sequencer;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Cen;
  logic [15:0] InstrIn;
  logic        ZeroIn;
  logic [7:0]  PC;
  logic [2:0]  SelA, SelB, SelWR, AluOp;
  logic        WE, ImmSel, Halted;
  logic [7:0]  Imm;

  typedef struct {
    logic [2:0] selWR;
    logic [2:0] aluOp;
    logic       immSel;
    logic [7:0] imm;
  } wrExp_t;

  wrExp_t      expQ[$];
  logic [15:0] mem [0:255];
  int          checks = 0;
  int          errors = 0;

  instr_sequencer #(.PC_W(8), .RST_PC(8'h00)) dut (
    .Clk(Clk), .Rst(Rst), .Cen(Cen), .InstrIn(InstrIn), .ZeroIn(ZeroIn),
    .PC(PC), .SelA(SelA), .SelB(SelB), .SelWR(SelWR), .WE(WE),
    .AluOp(AluOp), .ImmSel(ImmSel), .Imm(Imm), .Halted(Halted)
  );

  always #5 Clk = ~Clk;
  assign InstrIn = mem[PC];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pushWr(input logic [2:0] wr, input logic [2:0] op, input logic is, input logic [7:0] im);
    wrExp_t e;
    e.selWR = wr; e.aluOp = op; e.immSel = is; e.imm = im;
    expQ.push_back(e);
  endtask

  task automatic runN(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Every write pulse seen on the falling edge must match the oldest expected write.
  always @(negedge Clk) begin
    if (WE === 1'b1) begin
      checks++;
      assert (expQ.size() > 0) else begin
        errors++;
        $error("FAIL wr_unexpected: observed write to r%0d expected none", SelWR);
      end
      if (expQ.size() > 0) begin
        wrExp_t e;
        e = expQ.pop_front();
        check("wr_selWR", 32'(SelWR), 32'(e.selWR));
        check("wr_aluOp", 32'(AluOp), 32'(e.aluOp));
        check("wr_immSel", 32'(ImmSel), 32'(e.immSel));
        check("wr_imm", 32'(Imm), 32'(e.imm));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h1650;  // ADD R3,R1,R2
    mem[8'h01] = 16'h7AA5;  // LDI R5,A5
    mem[8'h02] = 16'h2248;  // SUB R1,R1,R1
    mem[8'h03] = 16'h9040;  // BRZ 40
    mem[8'h40] = 16'h2248;
    mem[8'h41] = 16'h9080;  // BRZ 80
    mem[8'h42] = 16'h80FF;  // JMP FF
    mem[8'hFF] = 16'h0000;  // NOP

    Rst = 1'b1; Cen = 1'b1; ZeroIn = 1'b0;
    runN(2);
    check("rst_pc", 32'(PC), 0);
    check("rst_we", 32'(WE), 0);
    check("rst_halted", 32'(Halted), 0);
    check("rst_sels", 32'({SelA, SelB, SelWR, AluOp, ImmSel, Imm}), 0);

    // Reset during WRITEBACK kills the write asynchronously.
    @(negedge Clk) Rst = 1'b0;
    runN(3);
    check("pre_rst_we", 32'(WE), 1);
    Rst = 1'b1;
    #1;
    check("midrst_we", 32'(WE), 0);
    check("midrst_pc", 32'(PC), 0);
    check("midrst_halted", 32'(Halted), 0);
    tick();
    check("midrst_pc_edge", 32'(PC), 0);
    @(negedge Clk) Rst = 1'b0;
    check("first_fetch_pc", 32'(PC), 0);

    // ADD R3,R1,R2 with WE only in cycle 4.
    pushWr(3'd3, 3'd0, 1'b0, 8'h50);
    tick();
    check("add_selA", 32'(SelA), 1);
    check("add_selB", 32'(SelB), 2);
    check("add_selWR", 32'(SelWR), 3);
    check("add_aluOp", 32'(AluOp), 0);
    check("add_we_c2", 32'(WE), 0);
    tick();
    check("add_we_c3", 32'(WE), 0);
    tick();
    check("add_we_c4", 32'(WE), 1);
    tick();
    check("add_we_next", 32'(WE), 0);
    check("add_pc", 32'(PC), 1);
    mem[8'h00] = 16'h6C80;  // MOV R6,R2 for the stall test later

    // LDI R5,A5
    pushWr(3'd5, 3'd0, 1'b1, 8'hA5);
    tick();
    check("ldi_immSel", 32'(ImmSel), 1);
    check("ldi_imm", 32'(Imm), 32'h A5);
    check("ldi_selWR", 32'(SelWR), 5);
    runN(3);
    check("ldi_pc", 32'(PC), 2);

    // SUB sets Z, BRZ taken.
    ZeroIn = 1'b1;
    pushWr(3'd1, 3'd1, 1'b0, 8'h48);
    runN(4);
    check("sub_pc", 32'(PC), 3);
    ZeroIn = 1'b0;
    runN(4);
    check("brz_taken_pc", 32'(PC), 32'h40);

    // SUB clears Z, BRZ falls through.
    pushWr(3'd1, 3'd1, 1'b0, 8'h48);
    runN(4);
    ZeroIn = 1'b1;
    runN(4);
    check("brz_nt_pc", 32'(PC), 32'h42);
    ZeroIn = 1'b0;

    // JMP FF then NOP wraps PC.
    runN(4);
    check("jmp_pc", 32'(PC), 32'hFF);
    runN(4);
    check("wrap_pc", 32'(PC), 0);

    // MOV R6,R2 stalled in WRITEBACK.
    pushWr(3'd6, 3'd5, 1'b0, 8'h80);
    tick();
    check("mov_aluOp", 32'(AluOp), 5);
    runN(2);
    Cen = 1'b0;
    #1;
    check("stall_we0", 32'(WE), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_we", 32'(WE), 0);
      check("stall_pc", 32'(PC), 0);
    end
    Cen = 1'b1;
    #1;
    check("stall_release_we", 32'(WE), 1);
    tick();
    check("stall_after_we", 32'(WE), 0);
    check("stall_after_pc", 32'(PC), 1);

    // HALT is terminal until reset.
    mem[8'h01] = 16'hF000;
    runN(2);
    check("halt_halted", 32'(Halted), 1);
    for (int i = 0; i < 22; i++) begin
      tick();
      check("halt_pc", 32'(PC), 1);
      check("halt_we", 32'(WE), 0);
      check("halt_hold", 32'(Halted), 1);
    end
    Rst = 1'b1;
    #1;
    check("halt_rst_halted", 32'(Halted), 0);
    check("halt_rst_pc", 32'(PC), 0);
    @(negedge Clk) Rst = 1'b0;
    check("sb_empty", 32'(expQ.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
